dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port data memory between two requesters: the CPU load/store port and a debug/loader port. The loader preloads the memory and inspects it during bring-up.
- Sequences every access through a fixed issue/wait/respond FSM.
- Gives the CPU a stall signal so the core freezes until its access completes.
- Sits between the core's MemWrite/ALU-result/write-data path and the data RAM, inside top.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from the mem_en cycle to valid mem_rdata; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset: rst=0 at a rising clk edge resets the block.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_rdata  out  DATA_W  registered load data.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_ready; combinational.
- dbg_req  in  1  debug request; held until dbg_ready.
- dbg_we  in  1  1=write, 0=read.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_rdata  out  DATA_W  registered read data.
- dbg_ready  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable; valid only with mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- grant_dbg  out  1  1 while the debug port owns the current transaction.
- busy  out  1  1 in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, owner latch=CPU, latency counter=0, RR pointer=CPU.
- FSM states:
  - IDLE: a winner is chosen only if some request is high. At the edge, latch winner id, we, addr and wdata into internal regs; go to ISSUE.
  - ISSUE, exactly 1 cycle: mem_en=1; mem_we/mem_addr/mem_wdata driven from the latched regs. Load counter with MEM_LATENCY; go to WAIT.
  - WAIT, MEM_LATENCY cycles: counter decrements each cycle. In the last WAIT cycle (counter==1), a read captures mem_rdata into the owner's rdata reg at the edge. Then go to RESP.
  - RESP, 1 cycle: owner's ready=1; go to IDLE.
- Outside ISSUE: mem_en=0, mem_we=0; mem_addr/mem_wdata hold their last values.
- Latency: request seen in IDLE cycle n gives ready high in cycle n+MEM_LATENCY+2. With the default, a request in cycle 0 gives ready in cycle 3.
- Throughput: at most one transaction per MEM_LATENCY+3 cycles. There is always one IDLE cycle between transactions.
- Writes follow the same sequence: the ready pulse is issued, and the rdata regs are unchanged.
- Each rdata reg holds its value until that port's next read completes.
- Latched inputs: requester inputs are sampled only in IDLE. Changes to addr/wdata/we after grant are ignored.
- Request dropped mid-transaction: the transaction still completes and the ready pulse is still issued.
- Request still high in the IDLE cycle after RESP: treated as a new request and re-arbitrated.
- Default arbitration: fixed priority, debug over CPU. Simultaneous requests grant debug.
- cpu_stall is purely combinational, so it is 0 in the RESP cycle. That lets the core advance on the same edge it consumes cpu_rdata.
- grant_dbg reflects the latched owner in ISSUE, WAIT and RESP; it is 0 in IDLE.
- Reset mid-operation: the transaction is aborted and all state returns to reset values. A pending write may or may not have reached memory, depending on whether ISSUE had occurred. No ready pulse is issued for the aborted transaction.

Optional Feature:
- Macro: DMEM_ARB_ROUND_ROBIN_EN.
- Defined: two-way round-robin. A 1-bit pointer names the preferred port and resets to CPU. On simultaneous requests the preferred port wins. After each grant the pointer flips to the non-granted port. A lone requester always wins, and the pointer updates on every grant.
- Undefined: fixed priority, debug over CPU; the pointer logic is absent.

Test Plan:
- CPU read: after reset, mem[0x10]=0xDEADBEEF; cpu_req=1, cpu_we=0, addr=0x10 in cycle 0. Expect mem_en=1 only in cycle 1, cpu_rdata=0xDEADBEEF and cpu_ready=1 in cycle 3, cpu_stall=1 in cycles 0-2.
- Debug write then CPU read: dbg writes 0x12345678 to 0x20, then CPU reads 0x20. Expect mem_we=1 in the first ISSUE cycle, dbg_ready pulse, then cpu_rdata=0x12345678. dbg_rdata stays 0.
- Simultaneous requests, macro undefined: cpu_req=dbg_req=1 for two transactions. Expect grants debug, CPU (cpu_stall high throughout the first) and grant_dbg=1 for the first only.
- Simultaneous requests, macro defined, both held continuously across 4 transactions: expect grant order CPU, DBG, CPU, DBG.
- MEM_LATENCY=3: CPU read in cycle 0. Expect mem_en in cycle 1 and cpu_ready in cycle 5. Changing cpu_addr during cycles 1-4 does not change mem_addr.
- Reset abort: assert rst=0 in the WAIT cycle. Expect busy=0, both ready=0, both rdata=0 next cycle, and no ready pulse afterwards until a new request.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data RAM between the CPU load/store
// port and the debug/loader port. Every access runs the fixed sequence
// IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP -> IDLE.
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-low reset
//   cpu_*              CPU request (req/we/addr/wdata), response (rdata/ready),
//                      cpu_stall = cpu_req & ~cpu_ready
//   dbg_*              debug/loader request and response
//   mem_*              RAM strobe, write enable, address, write data, read data
//   grant_dbg          debug port owns the in-flight transaction
//   busy               FSM is not in IDLE
//
// Build option: define DMEM_ARB_ROUND_ROBIN_EN for two-way round-robin
// arbitration. Without it, debug has fixed priority over the CPU.
module dmem_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 1      // 1..15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              grant_dbg,
   output logic              busy
);

   localparam logic [3:0] LAT = 4'(MEM_LATENCY);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   state_t     state, state_nxt;
   req_t       lat_q;          // request captured at grant; drives the RAM
   logic       owner_dbg;      // 1: debug owns the transaction
   logic [3:0] cnt;
   logic       any_req;
   logic       win_dbg;
   req_t       cpu_rq, dbg_rq;

   assign any_req = cpu_req | dbg_req;
   assign cpu_rq  = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
   assign dbg_rq  = '{we: dbg_we, addr: dbg_addr, wdata: dbg_wdata};

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic rr_ptr;               // preferred port on a tie: 0=CPU, 1=DBG
   assign win_dbg = dbg_req & (~cpu_req | rr_ptr);
`else
   assign win_dbg = dbg_req;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         lat_q     <= '0;
         owner_dbg <= 1'b0;
         cnt       <= '0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         rr_ptr    <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (any_req) begin
               owner_dbg <= win_dbg;
               lat_q     <= win_dbg ? dbg_rq : cpu_rq;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
               rr_ptr    <= ~win_dbg;   // prefer the loser next time
`endif
            end
            ISSUE: cnt <= LAT;
            WAIT: begin
               cnt <= cnt - 4'd1;
               // read data is valid in the last wait cycle only
               if (cnt == 4'd1 && !lat_q.we) begin
                  if (owner_dbg) dbg_rdata <= mem_rdata;
                  else           cpu_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      cpu_ready = 1'b0;
      dbg_ready = 1'b0;
      grant_dbg = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (any_req) state_nxt = ISSUE;
         end
         ISSUE: begin
            mem_en    = 1'b1;
            mem_we    = lat_q.we;
            grant_dbg = owner_dbg;
            state_nxt = WAIT;
         end
         WAIT: begin
            grant_dbg = owner_dbg;
            if (cnt == 4'd1) state_nxt = RESP;
         end
         RESP: begin
            grant_dbg = owner_dbg;
            cpu_ready = ~owner_dbg;
            dbg_ready = owner_dbg;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // address/data only change at grant, so they hold between transactions
   assign mem_addr  = lat_q.addr;
   assign mem_wdata = lat_q.wdata;
   assign cpu_stall = cpu_req & ~cpu_ready;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   // main DUT (MEM_LATENCY=1)
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        cpu_ready, cpu_stall, dbg_ready, mem_en, mem_we, grant_dbg, busy;
   // second DUT (MEM_LATENCY=3)
   logic        cpu_req3, cpu_we3, dbg_req3, dbg_we3;
   logic [31:0] cpu_addr3, cpu_wdata3, dbg_addr3, dbg_wdata3;
   logic [31:0] cpu_rdata3, dbg_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
   logic        cpu_ready3, cpu_stall3, dbg_ready3, mem_en3, mem_we3, grant_dbg3, busy3;

   int n_cmp = 0;
   int n_err = 0;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .grant_dbg(grant_dbg), .busy(busy));

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
      .cpu_rdata(cpu_rdata3), .cpu_ready(cpu_ready3), .cpu_stall(cpu_stall3),
      .dbg_req(dbg_req3), .dbg_we(dbg_we3), .dbg_addr(dbg_addr3), .dbg_wdata(dbg_wdata3),
      .dbg_rdata(dbg_rdata3), .dbg_ready(dbg_ready3),
      .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
      .mem_rdata(mem_rdata3), .grant_dbg(grant_dbg3), .busy(busy3));

   // RAM models: latency-1 and latency-3 read pipelines, plus a backdoor preload
   logic [31:0] mem  [0:255];
   logic [31:0] mem3 [0:255];
   logic [31:0] rd1;
   logic [31:0] rd3 [0:2];
   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [31:0] pl_data;

   always @(posedge clk) begin
      if (pl_en) begin
         mem[pl_addr]  <= pl_data;
         mem3[pl_addr] <= pl_data;
      end else begin
         if (mem_en && mem_we)   mem[mem_addr[7:0]]   <= mem_wdata;
         if (mem_en3 && mem_we3) mem3[mem_addr3[7:0]] <= mem_wdata3;
      end
      rd1    <= mem_en  ? mem[mem_addr[7:0]]   : 32'hxxxx_xxxx;
      rd3[0] <= mem_en3 ? mem3[mem_addr3[7:0]] : 32'hxxxx_xxxx;
      rd3[1] <= rd3[0];
      rd3[2] <= rd3[1];
   end
   assign mem_rdata  = rd1;
   assign mem_rdata3 = rd3[2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit exp_d;
      int n_sim;
      rst = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
      cpu_req3 = 0; cpu_we3 = 0; cpu_addr3 = '0; cpu_wdata3 = '0;
      dbg_req3 = 0; dbg_we3 = 0; dbg_addr3 = '0; dbg_wdata3 = '0;
      pl_en = 1'b1; pl_addr = 8'h10; pl_data = 32'hDEAD_BEEF;
      tick();
      pl_addr = 8'h30; pl_data = 32'hCAFE_F00D;
      tick();
      pl_en = 1'b0;

      // reset state
      chk("rst_busy", busy, 0);
      chk("rst_cpu_ready", cpu_ready, 0);
      chk("rst_dbg_ready", dbg_ready, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_dbg_rdata", dbg_rdata, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_grant_dbg", grant_dbg, 0);
      chk("rst_mem_addr", mem_addr, 0);
      rst = 1'b1;
      tick();

      // CPU read of 0x10: cycle 0 request
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      #1;
      chk("rd_c0_stall", cpu_stall, 1);
      chk("rd_c0_mem_en", mem_en, 0);
      tick();                                   // cycle 1: ISSUE
      chk("rd_c1_mem_en", mem_en, 1);
      chk("rd_c1_mem_we", mem_we, 0);
      chk("rd_c1_mem_addr", mem_addr, 32'h10);
      chk("rd_c1_stall", cpu_stall, 1);
      chk("rd_c1_grant_dbg", grant_dbg, 0);
      chk("rd_c1_busy", busy, 1);
      tick();                                   // cycle 2: WAIT
      chk("rd_c2_mem_en", mem_en, 0);
      chk("rd_c2_stall", cpu_stall, 1);
      chk("rd_c2_ready", cpu_ready, 0);
      tick();                                   // cycle 3: RESP
      chk("rd_c3_ready", cpu_ready, 1);
      chk("rd_c3_rdata", cpu_rdata, 32'hDEAD_BEEF);
      chk("rd_c3_stall", cpu_stall, 0);
      chk("rd_c3_mem_en", mem_en, 0);
      cpu_req = 0;
      tick();                                   // back in IDLE
      chk("rd_c4_ready", cpu_ready, 0);
      chk("rd_c4_busy", busy, 0);
      chk("rd_c4_mem_addr_hold", mem_addr, 32'h10);

      // debug write 0x12345678 -> 0x20
      dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wdata = 32'h1234_5678;
      tick();                                   // ISSUE
      chk("wr_mem_en", mem_en, 1);
      chk("wr_mem_we", mem_we, 1);
      chk("wr_mem_addr", mem_addr, 32'h20);
      chk("wr_mem_wdata", mem_wdata, 32'h1234_5678);
      chk("wr_grant_dbg", grant_dbg, 1);
      dbg_addr = 32'h99; dbg_wdata = 32'h0; dbg_we = 0;   // must be ignored
      tick();                                   // WAIT
      chk("wr_wait_mem_we", mem_we, 0);
      chk("wr_wait_mem_addr", mem_addr, 32'h20);
      tick();                                   // RESP
      chk("wr_dbg_ready", dbg_ready, 1);
      chk("wr_cpu_ready", cpu_ready, 0);
      chk("wr_dbg_rdata", dbg_rdata, 0);
      chk("wr_mem_content", mem[8'h20], 32'h1234_5678);
      dbg_req = 0;
      tick();
      chk("wr_idle_dbg_ready", dbg_ready, 0);

      // CPU reads back 0x20
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h20;
      tick(); tick(); tick();
      chk("rb_ready", cpu_ready, 1);
      chk("rb_rdata", cpu_rdata, 32'h1234_5678);
      chk("rb_dbg_rdata", dbg_rdata, 0);
      cpu_req = 0;
      tick();

      // simultaneous requests, from a fresh reset
      rst = 1'b0;
      tick();
      chk("rst2_cpu_rdata", cpu_rdata, 0);
      rst = 1'b1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
      #1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      n_sim = 4;
`else
      n_sim = 2;
`endif
      for (int t = 0; t < n_sim; t++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         exp_d = (t % 2 == 1);              // CPU, DBG, CPU, DBG
`else
         exp_d = (t == 0);                  // DBG then CPU
`endif
         chk($sformatf("sim%0d_idle_busy", t), busy, 0);
         tick();                            // ISSUE
         chk($sformatf("sim%0d_grant_dbg", t), grant_dbg, exp_d);
         chk($sformatf("sim%0d_mem_addr", t), mem_addr, exp_d ? 32'h20 : 32'h10);
         chk($sformatf("sim%0d_stall", t), cpu_stall, 1);
         tick(); tick();                    // RESP
         chk($sformatf("sim%0d_dbg_ready", t), dbg_ready, exp_d);
         chk($sformatf("sim%0d_cpu_ready", t), cpu_ready, !exp_d);
         chk($sformatf("sim%0d_stall_resp", t), cpu_stall, exp_d);
         if (exp_d) chk($sformatf("sim%0d_dbg_rdata", t), dbg_rdata, 32'h1234_5678);
         else       chk($sformatf("sim%0d_cpu_rdata", t), cpu_rdata, 32'hDEAD_BEEF);
`ifndef DMEM_ARB_ROUND_ROBIN_EN
         if (exp_d) dbg_req = 0;
`endif
         tick();
      end
      cpu_req = 0; dbg_req = 0;
      tick();

      // latency-3 instance: read 0x30, address changes after grant are ignored
      cpu_req3 = 1; cpu_we3 = 0; cpu_addr3 = 32'h30;
      tick();                                   // cycle 1
      chk("l3_c1_mem_en", mem_en3, 1);
      chk("l3_c1_mem_addr", mem_addr3, 32'h30);
      cpu_addr3 = 32'h44;
      tick();                                   // cycle 2
      chk("l3_c2_mem_en", mem_en3, 0);
      chk("l3_c2_mem_addr", mem_addr3, 32'h30);
      cpu_addr3 = 32'h55;
      tick();                                   // cycle 3
      chk("l3_c3_ready", cpu_ready3, 0);
      tick();                                   // cycle 4
      chk("l3_c4_ready", cpu_ready3, 0);
      chk("l3_c4_stall", cpu_stall3, 1);
      chk("l3_c4_mem_addr", mem_addr3, 32'h30);
      tick();                                   // cycle 5
      chk("l3_c5_ready", cpu_ready3, 1);
      chk("l3_c5_rdata", cpu_rdata3, 32'hCAFE_F00D);
      cpu_req3 = 0;
      tick();
      chk("l3_c6_busy", busy3, 0);

      // reset abort during WAIT
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10;
      tick();                                   // ISSUE
      tick();                                   // WAIT
      chk("ab_wait_busy", busy, 1);
      rst = 1'b0;
      tick();
      chk("ab_busy", busy, 0);
      chk("ab_cpu_ready", cpu_ready, 0);
      chk("ab_dbg_ready", dbg_ready, 0);
      chk("ab_cpu_rdata", cpu_rdata, 0);
      chk("ab_dbg_rdata", dbg_rdata, 0);
      chk("ab_grant_dbg", grant_dbg, 0);
      rst = 1'b1;
      dbg_req = 0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("ab_post%0d_dbg_ready", k), dbg_ready, 0);
         chk($sformatf("ab_post%0d_busy", k), busy, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
